// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } arbState_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and bus-side signals of the memory port arbiter.
// master = arbiter view, slave = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;

    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_be;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;

    logic                  stall_if;
    logic                  stall_mem;
    logic                  timeout_err;

    modport master (
        input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_be,
               bus_ack, bus_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be,
               stall_if, stall_mem, timeout_err
    );

    modport slave (
        output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, mem_be,
               bus_ack, bus_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready,
               bus_req, bus_we, bus_addr, bus_wdata, bus_be,
               stall_if, stall_mem, timeout_err
    );

endinterface

// File: rtl/mem_arb_wdog.sv
// Bus watchdog: down-counter reloaded on clr; expired marks the LIMIT-th
// consecutive enabled cycle.
module mem_arb_wdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(LIMIT - 1);

    logic [CntW-1:0] cntQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntQ <= Reload;
        end else if (clr) begin
            cntQ <= Reload;
        end else if (en && (cntQ != '0)) begin
            cntQ <= cntQ - 1'b1;
        end
    end

    assign expired = en && (cntQ == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory bus between the IF and MEM pipeline stages.
// Optional bus watchdog is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master arb
);

    // state    | meaning
    // IDLE     | sample IF/MEM requests and grant one side
    // BUSY_IF  | IF command held on the bus until ack
    // BUSY_MEM | MEM command held on the bus until ack
    // RESP     | one-cycle ready pulse to the served side

    arbState_t stateQ, stateD;
    grant_t    lastGrant;

    logic ifPend, memPend, anyPend, pickMem;
    logic busyNow, grantEn, endBusy, wdogExpired;
    logic [DATA_W-1:0] respData;

    logic                busReqQ, busWeQ;
    logic [ADDR_W-1:0]   busAddrQ;
    logic [DATA_W-1:0]   busWdataQ;
    logic [DATA_W/8-1:0] busBeQ;
    logic                ifReadyQ, memReadyQ;
    logic [DATA_W-1:0]   ifRdataQ, memRdataQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateQ <= IDLE;
        else     stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:              if (anyPend) stateD = pickMem ? BUSY_MEM : BUSY_IF;
            BUSY_IF, BUSY_MEM: if (endBusy) stateD = RESP;
            RESP:              stateD = IDLE;
            default:           stateD = IDLE;
        endcase
    end

    // On a conflict the side not served last wins; ack beats watchdog expiry.
    always_comb begin
        ifPend   = arb.if_req;
        memPend  = arb.mem_rd_en | arb.mem_wr_en;
        anyPend  = ifPend | memPend;
        pickMem  = memPend && (!ifPend || (lastGrant == GNT_IF));
        busyNow  = (stateQ == BUSY_IF) || (stateQ == BUSY_MEM);
        grantEn  = (stateQ == IDLE) && anyPend;
        endBusy  = busyNow && (arb.bus_ack || wdogExpired);
        respData = arb.bus_ack ? arb.bus_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant <= GNT_IF;
            busReqQ   <= 1'b0;
            busWeQ    <= 1'b0;
            busAddrQ  <= '0;
            busWdataQ <= '0;
            busBeQ    <= '0;
            ifReadyQ  <= 1'b0;
            memReadyQ <= 1'b0;
            ifRdataQ  <= '0;
            memRdataQ <= '0;
        end else begin
            ifReadyQ  <= 1'b0;
            memReadyQ <= 1'b0;
            if (grantEn) begin
                busReqQ <= 1'b1;
                if (pickMem) begin
                    busWeQ    <= arb.mem_wr_en;
                    busAddrQ  <= arb.mem_addr;
                    busWdataQ <= arb.mem_wdata;
                    busBeQ    <= arb.mem_be;
                end else begin
                    busWeQ    <= 1'b0;
                    busAddrQ  <= arb.if_addr;
                    busWdataQ <= '0;
                    busBeQ    <= '0;
                end
            end
            if (endBusy) begin
                busReqQ <= 1'b0;
                if (stateQ == BUSY_MEM) begin
                    memReadyQ <= 1'b1;
                    memRdataQ <= respData;
                    lastGrant <= GNT_MEM;
                end else begin
                    ifReadyQ  <= 1'b1;
                    ifRdataQ  <= respData;
                    lastGrant <= GNT_IF;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeoutErrQ;

    mem_arb_wdog #(.LIMIT(TIMEOUT_CYC)) uWdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (grantEn),
        .en      (busyNow && !arb.bus_ack),
        .expired (wdogExpired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              timeoutErrQ <= 1'b0;
        else if (wdogExpired) timeoutErrQ <= 1'b1;
    end

    assign arb.timeout_err = timeoutErrQ;
`else
    assign wdogExpired     = 1'b0;
    assign arb.timeout_err = 1'b0;
`endif

    assign arb.bus_req   = busReqQ;
    assign arb.bus_we    = busWeQ;
    assign arb.bus_addr  = busAddrQ;
    assign arb.bus_wdata = busWdataQ;
    assign arb.bus_be    = busBeQ;
    assign arb.if_ready  = ifReadyQ;
    assign arb.if_rdata  = ifRdataQ;
    assign arb.mem_ready = memReadyQ;
    assign arb.mem_rdata = memRdataQ;
    assign arb.stall_if  = arb.if_req & ~ifReadyQ;
    assign arb.stall_mem = (arb.mem_rd_en | arb.mem_wr_en) & ~memReadyQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level timing model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ifReqD, memRdD, memWrD, busAckD;
    logic [31:0] ifAddrD, memAddrD, memWdataD, busRdataD;
    logic [3:0]  memBeD;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) arb ();

    assign arb.if_req    = ifReqD;
    assign arb.if_addr   = ifAddrD;
    assign arb.mem_rd_en = memRdD;
    assign arb.mem_wr_en = memWrD;
    assign arb.mem_addr  = memAddrD;
    assign arb.mem_wdata = memWdataD;
    assign arb.mem_be    = memBeD;
    assign arb.bus_ack   = busAckD;
    assign arb.bus_rdata = busRdataD;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb.master)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Transaction model: edge-count timestamps for when the arbiter next samples,
    // the transaction currently on the bus, and what each requester was last given.
    int          edgeCnt, mNextSample, mBusyCnt;
    bit          mBusy, mSideMem, mLastMem, mWe, mTimeoutErr, mLastTimedOut;
    logic [31:0] mAddr, mWdata, mIfData, mMemData;
    logic [3:0]  mBe;
    bit          expIfRdy, expMemRdy;
    int          served[$];

    task automatic modelReset();
        mBusy = 0; mLastMem = 0; mTimeoutErr = 0; mLastTimedOut = 0;
        mIfData = '0; mMemData = '0; expIfRdy = 0; expMemRdy = 0;
        edgeCnt = 0; mNextSample = 1; mBusyCnt = 0;
    endtask

    task automatic modelFinish(input logic [31:0] data, input bit timedOut);
        mBusy = 0;
        mLastMem = mSideMem;
        mNextSample = edgeCnt + 2;
        mLastTimedOut = timedOut;
        if (timedOut) mTimeoutErr = 1;
        if (mSideMem) begin expMemRdy = 1; mMemData = data; end
        else          begin expIfRdy  = 1; mIfData  = data; end
    endtask

    task automatic modelEdge();
        expIfRdy = 0; expMemRdy = 0;
        edgeCnt++;
        if (mBusy) begin
            if (busAckD) modelFinish(busRdataD, 1'b0);
            else begin
                mBusyCnt++;
                if (TO_EN && mBusyCnt == TMO) modelFinish(32'h0, 1'b1);
            end
        end else if (edgeCnt >= mNextSample && (ifReqD || memRdD || memWrD)) begin
            mSideMem = (memRdD || memWrD) && (!ifReqD || !mLastMem);
            mBusy = 1; mBusyCnt = 0;
            if (mSideMem) begin
                mWe = memWrD; mAddr = memAddrD; mWdata = memWdataD; mBe = memBeD;
            end else begin
                mWe = 0; mAddr = ifAddrD;
            end
        end
    endtask

    task automatic checkOutputs();
        checkVal("bus_req", arb.bus_req, mBusy);
        if (mBusy) begin
            checkVal("bus_we", arb.bus_we, mWe);
            checkVal("bus_addr", arb.bus_addr, mAddr);
            if (mWe) begin
                checkVal("bus_wdata", arb.bus_wdata, mWdata);
                checkVal("bus_be", arb.bus_be, mBe);
            end
        end
        checkVal("if_ready", arb.if_ready, expIfRdy);
        checkVal("mem_ready", arb.mem_ready, expMemRdy);
        checkVal("if_rdata", arb.if_rdata, mIfData);
        if (expMemRdy && (!mWe || mLastTimedOut)) checkVal("mem_rdata", arb.mem_rdata, mMemData);
        checkVal("stall_if", arb.stall_if, ifReqD && !expIfRdy);
        checkVal("stall_mem", arb.stall_mem, (memRdD || memWrD) && !expMemRdy);
        checkVal("timeout_err", arb.timeout_err, mTimeoutErr);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge,
    // and a requester drops its request once it has seen ready.
    task automatic step();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutputs();
        if (expIfRdy) ifReqD = 1'b0;
        if (expMemRdy) begin memRdD = 1'b0; memWrD = 1'b0; end
    endtask

    task automatic randomInputs(input int ackMode);
        int k;
        if (!ifReqD && $urandom_range(0, 1) == 1) begin
            ifReqD  = 1'b1;
            ifAddrD = $urandom & 32'hFFFF_FFFC;
        end
        if (!memRdD && !memWrD && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 3);
            memRdD    = (k != 2);
            memWrD    = (k >= 2);
            memAddrD  = $urandom & 32'hFFFF_FFFC;
            memWdataD = $urandom;
            memBeD    = 4'($urandom_range(1, 15));
        end
        case (ackMode)
            0:       busAckD = ($urandom_range(0, 3) == 0);
            1:       busAckD = 1'b1;
            default: busAckD = ($urandom_range(0, 1) == 1);
        endcase
        busRdataD = $urandom;
    endtask

    initial begin
        ifReqD = 0; memRdD = 0; memWrD = 0; busAckD = 0;
        ifAddrD = '0; memAddrD = '0; memWdataD = '0; memBeD = '0; busRdataD = '0;
        modelReset();

        repeat (2) @(negedge clk);
        checkVal("rst_bus_req", arb.bus_req, 0);
        checkVal("rst_bus_we", arb.bus_we, 0);
        checkVal("rst_bus_addr", arb.bus_addr, 0);
        checkVal("rst_bus_wdata", arb.bus_wdata, 0);
        checkVal("rst_bus_be", arb.bus_be, 0);
        checkVal("rst_if_ready", arb.if_ready, 0);
        checkVal("rst_mem_ready", arb.mem_ready, 0);
        checkVal("rst_if_rdata", arb.if_rdata, 0);
        checkVal("rst_mem_rdata", arb.mem_rdata, 0);
        checkVal("rst_timeout_err", arb.timeout_err, 0);

        // Both sides pending from reset with ack held high: MEM first, then alternate.
        ifReqD = 1; ifAddrD = 32'h0040_0100;
        memRdD = 1; memAddrD = 32'h1001_0000;
        busAckD = 1; busRdataD = $urandom;
        @(negedge clk);
        rst = 0;
        modelReset();
        for (int i = 0; i < 12; i++) begin
            step();
            if (arb.mem_ready) served.push_back(1);
            if (arb.if_ready)  served.push_back(0);
            if (!ifReqD) begin ifReqD = 1; ifAddrD = ifAddrD + 32'd4; end
            if (!memRdD) begin memRdD = 1; memAddrD = memAddrD + 32'd4; end
            busRdataD = $urandom;
        end
        checkVal("conflict_count", served.size(), 4);
        for (int i = 0; i < 4 && i < served.size(); i++)
            checkVal($sformatf("conflict_order%0d", i), served[i], (i % 2 == 0) ? 1 : 0);
        ifReqD = 0; memRdD = 0; busAckD = 0;
        repeat (3) step();

        // Single fetch, ack two cycles after bus_req.
        ifReqD = 1; ifAddrD = 32'h0040_0000;
        step();
        checkVal("fetch_bus_req", arb.bus_req, 1);
        checkVal("fetch_bus_addr", arb.bus_addr, 32'h0040_0000);
        checkVal("fetch_bus_we", arb.bus_we, 0);
        step();
        step();
        checkVal("fetch_stall", arb.stall_if, 1);
        busAckD = 1; busRdataD = 32'h2402_0005;
        step();
        checkVal("fetch_ready", arb.if_ready, 1);
        checkVal("fetch_rdata", arb.if_rdata, 32'h2402_0005);
        busAckD = 0;
        repeat (2) step();

        // Store with immediate ack.
        memWrD = 1; memAddrD = 32'h1001_0004; memWdataD = 32'hCAFE_F00D; memBeD = 4'hF;
        step();
        checkVal("store_bus_we", arb.bus_we, 1);
        checkVal("store_bus_addr", arb.bus_addr, 32'h1001_0004);
        checkVal("store_bus_wdata", arb.bus_wdata, 32'hCAFE_F00D);
        checkVal("store_bus_be", arb.bus_be, 4'hF);
        busAckD = 1; busRdataD = $urandom;
        step();
        checkVal("store_ready", arb.mem_ready, 1);
        checkVal("store_if_ready", arb.if_ready, 0);
        busAckD = 0;
        repeat (2) step();

        // Asynchronous reset while a load waits for ack.
        memRdD = 1; memAddrD = 32'h1001_0020;
        step();
        checkVal("rst_pre_bus_req", arb.bus_req, 1);
        step();
        #2 rst = 1;
        #1 checkVal("rst_async_bus_req", arb.bus_req, 0);
        memRdD = 0; busAckD = 1;
        @(negedge clk);
        rst = 0;
        modelReset();
        repeat (4) step();
        busAckD = 0;

        for (int i = 0; i < 1500; i++) begin
            randomInputs((i / 100) % 3);
            step();
        end

        // Drain outstanding requests, then leave a load unacknowledged.
        busAckD = 1;
        repeat (10) step();
        busAckD = 0;
        memRdD = 1; memWrD = 0; memAddrD = 32'h1001_0040;
        repeat (TMO + 4) step();
        checkVal("timeout_err_set", arb.timeout_err, TO_EN);
        busAckD = 1;
        repeat (4) step();
        for (int i = 0; i < 200; i++) begin
            randomInputs(2);
            step();
        end
        checkVal("timeout_err_sticky", arb.timeout_err, TO_EN);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory bus between the instruction-fetch (IF) stage and the MEM stage of the 5-stage MIPS pipeline. The MEM-stage side is driven by the decoded MemRead_en / MemWrite_en strobes of the instruction in EX/MEM. The block sequences each access as a req/ack bus transaction and returns per-requester ready pulses. It also produces the stall signals consumed by the hazard/stall logic.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only when compiled in.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF wants an instruction word; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched word; valid when if_ready.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_rd_en  in  1  load in EX/MEM (MemRead_en).
- mem_wr_en  in  1  store in EX/MEM (MemWrite_en).
- mem_addr, mem_wdata  in  ADDR_W, DATA_W  load/store address and store data.
- mem_be  in  DATA_W/8  store byte enables.
- mem_rdata  out  DATA_W  load data; valid when mem_ready.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- bus_req, bus_we  out  1  bus request and write qualifier.
- bus_addr, bus_wdata, bus_be  out  ADDR_W, DATA_W, DATA_W/8  bus command fields.
- bus_ack  in  1  slave completion; bus_rdata is valid in the same cycle.
- bus_rdata  in  DATA_W  slave read data.
- stall_if, stall_mem  out  1  pipeline stall requests.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE: sample requests. A MEM request is mem_rd_en|mem_wr_en.
  - Only one side pending: grant that side.
  - Both pending: grant the side not granted last (last_grant register). last_grant resets to IF, so MEM wins the first conflict.
  - Granting latches the command fields into bus_* registers, sets bus_req=1, and moves to BUSY_IF or BUSY_MEM.
  - If mem_rd_en and mem_wr_en are both high, the access is treated as a write (bus_we=1).
- BUSY_*: bus_req and all bus_* fields are held constant until bus_ack=1. On ack, capture bus_rdata, drop bus_req, update last_grant, and move to RESP.
- RESP: pulse if_ready or mem_ready for the granted side, with rdata driven from the capture register. Then return to IDLE.
- rdata registers hold their value until the next capture. Write accesses also capture bus_rdata, and that value is don't-care.
- stall_if = if_req & ~if_ready. stall_mem = (mem_rd_en|mem_wr_en) & ~mem_ready. Both are combinational from registered ready.
- Reset mid-transaction: all state clears immediately and bus_req drops. The slave must tolerate an abandoned request.

## Timing
- Reset values:
  - state=IDLE, last_grant=IF.
  - bus_req, bus_we, bus_addr, bus_wdata, bus_be = 0.
  - if_ready, mem_ready, if_rdata, mem_rdata = 0.
  - timeout_err = 0.
- Request seen in IDLE at cycle N → bus_req high at N+1.
- bus_ack at N+1+k (k≥0) → ready pulse at N+2+k, next IDLE sampling at N+3+k.
- Minimum access latency is 3 cycles, request to ready.
- bus_ack outside BUSY_* is ignored.
- A requester must not change addr/data while its request is high and ready is low.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A watchdog counts consecutive BUSY_* cycles with bus_ack=0.
  - When the count reaches TIMEOUT_CYC: drop bus_req, enter RESP, return rdata=0, and set timeout_err. timeout_err stays sticky until rst.
  - The counter clears on every grant.
- Not defined: no counter is built, BUSY_* waits indefinitely, and timeout_err is tied to 0.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_MEM, RESP);
  - the grant encoding (GNT_IF=0, GNT_MEM=1);
  - the default width constants.
- One sub-module, mem_arb_wdog: watchdog counter with inputs clr/en and output expired. It is instantiated only under MEM_ARB_TIMEOUT_EN.

## Test plan
- Single IF fetch: if_req with if_addr=0x0040_0000, slave acks 2 cycles after bus_req with 0x2402_0005 → bus_addr=0x0040_0000, bus_we=0, if_ready pulses at cycle N+4 with if_rdata=0x2402_0005, stall_if high through N+3.
- Store: mem_wr_en, addr=0x1001_0004, wdata=0xCAFE_F00D, be=4'b1111, immediate ack → bus_we=1 with fields matching, mem_ready at N+2, if_ready stays 0.
- Conflict: if_req and mem_rd_en both high from reset → MEM served first, then IF. Repeat with both still pending → the sides alternate.
- Async reset asserted while in BUSY_MEM and before ack → bus_req=0 in the same cycle; after release, state=IDLE and no ready pulse occurs.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, bus_ack never asserted → bus_req drops after 8 busy cycles, mem_ready pulses with mem_rdata=0, timeout_err=1 and stays high across later accesses.
- Back-to-back loads with ack held high continuously → each load completes in exactly 3 cycles and bus fields never change while bus_req=1.
